dp_shift_right_iter: RTL and testbench

//  Multi-cycle shifter-operand unit for ARMv4 data-processing shift types 01 (LSR), 10 (ASR) and 11 (ROR/RRX).
//  It is the right-shift/rotate counterpart of the combinational LSL (type 00) path.

---
 rtl/dp_shift_right_iter.sv | 136 +++++++++++++
 tb/tb_dp_shift_right_iter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_shift_right_iter.sv
// Multi-cycle LSR/ASR/ROR/RRX shifter-operand unit for ARMv4 data processing.
// Edge cases resolve in one cycle; ordinary shifts iterate STEP bits per cycle.
module dp_shift_right_iter #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic [31:0] Rm_data,
    input  logic        is_DPIS,
    input  logic        is_DPRS,
    input  logic        C,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] shift_res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state;
    logic [31:0] work;
    logic [5:0]  remaining;
    logic [1:0]  stype;
    logic [32:0] res_q;

    logic [7:0]  n;
    logic        direct;
    logic [32:0] direct_res;
    logic [5:0]  k;
    logic [4:0]  k_idx;
    logic [31:0] shifted;
    logic        step_carry;

    // is_DPRS selects the same behaviour as the default encoding, so only is_DPIS steers the decode.
    logic unused_dprs;
    assign unused_dprs = is_DPRS;

    assign n = is_DPIS ? {3'b000, shift_amt[4:0]} : shift_amt;

    always_comb begin
        direct     = 1'b1;
        direct_res = {C, Rm_data};
        if (shift_type != 2'b00 && !(!is_DPIS && n == 8'd0)) begin
            case (shift_type)
                2'b01: begin
                    if (n == 8'd0 || n == 8'd32)
                        direct_res = {Rm_data[31], 32'h0};
                    else if (n > 8'd32)
                        direct_res = 33'h0;
                    else
                        direct = 1'b0;
                end
                2'b10: begin
                    if (n == 8'd0 || n >= 8'd32)
                        direct_res = {Rm_data[31], {32{Rm_data[31]}}};
                    else
                        direct = 1'b0;
                end
                default: begin
                    // Only the immediate form reaches here with n==0, which is RRX.
                    if (n == 8'd0)
                        direct_res = {Rm_data[0], C, Rm_data[31:1]};
                    else if (n[4:0] == 5'd0)
                        direct_res = {Rm_data[31], Rm_data};
                    else
                        direct = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        k     = (remaining < STEP_W) ? remaining : STEP_W;
        k_idx = 5'(k - 6'd1);
        case (stype)
            2'b01:   shifted = work >> k;
            2'b10:   shifted = $signed(work) >>> k;
            default: shifted = (work >> k) | (work << (6'd32 - k));
        endcase
        step_carry = work[k_idx];
    end

    // Only the last step's carry-out survives, so it is folded straight into the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= 32'h0;
            remaining <= 6'd0;
            stype     <= 2'b00;
            res_q     <= 33'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (direct) begin
                            res_q <= direct_res;
                            state <= DONE;
                        end else begin
                            work      <= Rm_data;
                            remaining <= {1'b0, n[4:0]};
                            stype     <= shift_type;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        res_q <= {step_carry, shifted};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shift_res = res_q;

endmodule

// File: tb/tb_dp_shift_right_iter.sv
// Bench for dp_shift_right_iter: directed vector table, handshake/reset sequences,
// and a randomised sweep scored against an ARM shifter-operand reference model.
module tb_dp_shift_right_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic [31:0] Rm_data;
    logic        is_DPIS;
    logic        is_DPRS;
    logic        C;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] shift_res;

    always #5 clk = ~clk;

    dp_shift_right_iter #(.STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .shift_type(shift_type), .shift_amt(shift_amt), .Rm_data(Rm_data),
        .is_DPIS(is_DPIS), .is_DPRS(is_DPRS), .C(C), .out_valid(out_valid),
        .out_ready(out_ready), .shift_res(shift_res)
    );

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  amt;
        logic [31:0] rm;
        logic        c;
        logic        dpis;
        logic        dprs;
        logic [32:0] exp;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb_q[$];
    bit          stall_mode = 1'b0;
    vec_t        vecs[13];

    function automatic logic [32:0] golden(input logic [1:0] t, input logic [7:0] amt,
                                           input logic [31:0] rm, input logic c, input logic dpis);
        int          n;
        int          m;
        logic [63:0] dbl;
        logic [31:0] r;
        n = dpis ? int'(amt[4:0]) : int'(amt);
        if (t == 2'b00 || (!dpis && n == 0)) return {c, rm};
        case (t)
            2'b01: begin
                if (n == 0 || n == 32) return {rm[31], 32'h0};
                if (n > 32) return 33'h0;
                r = rm >> n;
                return {rm[n-1], r};
            end
            2'b10: begin
                if (n == 0 || n >= 32) return {rm[31], {32{rm[31]}}};
                r = $signed(rm) >>> n;
                return {rm[n-1], r};
            end
            default: begin
                if (dpis && n == 0) return {rm[0], c, rm[31:1]};
                m = n % 32;
                if (m == 0) return {rm[31], rm};
                dbl = {rm, rm} >> m;
                return {rm[m-1], dbl[31:0]};
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randReady();
        if (stall_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Drives one request, pushes its expected result, optionally waits for out_valid.
    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] amt, input logic [31:0] rm,
                                 input logic c, input logic dpis, input logic dprs,
                                 input logic [32:0] exp, input bit wait_done, output int lat);
        int waitc = 0;
        lat = -1;
        while (!in_ready && waitc < 200) begin
            randReady();
            tick();
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at %b required 1", in_ready);
            return;
        end
        shift_type = t;
        shift_amt  = amt;
        Rm_data    = rm;
        C          = c;
        is_DPIS    = dpis;
        is_DPRS    = dprs;
        in_valid   = 1'b1;
        randReady();
        tick();
        in_valid   = 1'b0;
        Rm_data    = $urandom;
        C          = 1'($urandom_range(0, 1));
        shift_amt  = 8'($urandom);
        sb_q.push_back(exp);
        if (!wait_done) return;
        lat = 1;
        while (!out_valid && lat < 100) begin
            randReady();
            tick();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: out_valid %b required 1", out_valid);
        end
    endtask

    // Scoreboard: every handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL result: unexpected result %h with empty scoreboard", shift_res);
            end else begin
                checkOutput("result", shift_res, sb_q.pop_front());
            end
        end
    end

    initial begin
        int          lat;
        logic [32:0] held;
        logic [31:0] rm;
        logic        c;
        logic        dprs;

        vecs[0]  = '{2'b01, 8'd4,    32'h8000_00F0, 1'b0, 1'b1, 1'b0, {1'b0, 32'h0800_000F}, 2};
        vecs[1]  = '{2'b10, 8'd40,   32'h8000_0001, 1'b0, 1'b0, 1'b1, {1'b1, 32'hFFFF_FFFF}, 1};
        vecs[2]  = '{2'b10, 8'd0,    32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, {1'b0, 32'h0000_0000}, 1};
        vecs[3]  = '{2'b11, 8'd0,    32'h0000_0003, 1'b1, 1'b1, 1'b0, {1'b1, 32'h8000_0001}, 1};
        vecs[4]  = '{2'b11, 8'h20,   32'h8000_0000, 1'b0, 1'b0, 1'b1, {1'b1, 32'h8000_0000}, 1};
        vecs[5]  = '{2'b00, 8'd5,    32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, {1'b1, 32'hDEAD_BEEF}, 1};
        vecs[6]  = '{2'b01, 8'd32,   32'h8000_0000, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0000_0000}, 1};
        vecs[7]  = '{2'b01, 8'd33,   32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, {1'b0, 32'h0000_0000}, 1};
        vecs[8]  = '{2'b10, 8'd1,    32'h8000_0003, 1'b0, 1'b0, 1'b1, {1'b1, 32'hC000_0001}, 2};
        vecs[9]  = '{2'b11, 8'd8,    32'h1234_5678, 1'b0, 1'b1, 1'b0, {1'b0, 32'h7812_3456}, 3};
        vecs[10] = '{2'b11, 8'h24,   32'h0000_000F, 1'b0, 1'b0, 1'b1, {1'b1, 32'hF000_0000}, 2};
        vecs[11] = '{2'b01, 8'h40,   32'h8000_0000, 1'b0, 1'b1, 1'b1, {1'b1, 32'h0000_0000}, 1};
        vecs[12] = '{2'b10, 8'd31,   32'h4000_0000, 1'b0, 1'b1, 1'b0, {1'b1, 32'h0000_0000}, 9};

        rst_n = 1'b0; in_valid = 1'b0; shift_type = 2'b00; shift_amt = 8'd0;
        Rm_data = 32'h0; is_DPIS = 1'b0; is_DPRS = 1'b0; C = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("reset_in_ready", 33'(in_ready), 33'd1);
        checkOutput("reset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("reset_shift_res", shift_res, 33'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].t, vecs[i].amt, vecs[i].rm, vecs[i].c, vecs[i].dpis,
                          vecs[i].dprs, vecs[i].exp, 1'b1, lat);
            checkOutput($sformatf("vec%0d_latency", i), 33'(lat), 33'(vecs[i].lat));
        end

        // Long LSR with the consumer stalling for five cycles.
        tick();
        out_ready = 1'b0;
        applyStimulus(2'b01, 8'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0000_0001}, 1'b1, lat);
        checkOutput("lsr31_latency", 33'(lat), 33'd9);
        held = shift_res;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_res", i), shift_res, held);
            checkOutput($sformatf("stall%0d_in_ready", i), 33'(in_ready), 33'd0);
            checkOutput($sformatf("stall%0d_out_valid", i), 33'(out_valid), 33'd1);
        end
        out_ready = 1'b1;
        tick();

        // Reset in the middle of an iterated rotate drops it entirely.
        applyStimulus(2'b11, 8'd29, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 33'h0, 1'b0, lat);
        tick();
        rst_n = 1'b0;
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        checkOutput("midreset_in_ready", 33'(in_ready), 33'd1);
        checkOutput("midreset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("midreset_shift_res", shift_res, 33'h0);
        applyStimulus(2'b01, 8'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, {1'b1, 32'h1234_5678}, 1'b1, lat);
        checkOutput("postreset_latency", 33'(lat), 33'd1);

        // Randomised sweep with consumer back-pressure.
        stall_mode = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int d = 0; d < 2; d++) begin
                for (int a = 0; a < 256; a++) begin
                    rm   = $urandom;
                    c    = 1'($urandom_range(0, 1));
                    dprs = 1'($urandom_range(0, 1));
                    applyStimulus(2'(t), 8'(a), rm, c, 1'(d), dprs,
                                  golden(2'(t), 8'(a), rm, c, 1'(d)), 1'b1, lat);
                end
            end
        end
        stall_mode = 1'b0;
        out_ready  = 1'b1;
        repeat (3) tick();
        checkOutput("scoreboard_empty", 33'(sb_q.size()), 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
